pmix_code_ctrl: RTL and testbench

//  CDR phase-code controller driving the phase-mixer clock generator code input (0..359 deg).

---
 rtl/pmix_code_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_pmix_code_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmix_code_ctrl.sv
// Phase-mixer code controller: accumulates bang-bang PD votes over fixed windows and
// steps a modulo-CODE_MAX phase code (coarse in ACQ, fine in TRACK), with manual load.
module pmix_code_ctrl #(
    parameter int CODE_W     = 9,
    parameter int CODE_MAX   = 360,
    parameter int WIN_LEN    = 16,
    parameter int THR        = 4,
    parameter int ACQ_STEP   = 8,
    parameter int TRK_STEP   = 1,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_WIN   = 8,
    parameter int UNLOCK_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              freeze,
    input  logic              vote_vld,
    input  logic              vote_up,
    input  logic              vote_dn,
    input  logic              load_req,
    input  logic [CODE_W-1:0] load_code,
    output logic              load_ack,
    output logic              load_err,
    output logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] code_90,
    output logic              code_upd,
    output logic              locked,
    output logic [1:0]        state
);
    // state | meaning
    // IDLE  | loop disabled, code held, window empty
    // ACQ   | coarse steps, counting quiet windows toward lock
    // TRACK | fine steps, counting same-direction steps toward unlock
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    localparam int NET_W = $clog2(WIN_LEN) + 2;
    localparam int WC_W  = $clog2(WIN_LEN) + 1;
    localparam int SC_W  = $clog2(SETTLE_CYC + 1);
    localparam int QC_W  = $clog2(LOCK_WIN + 1);
    localparam int RC_W  = $clog2(UNLOCK_RUN + 1);

    localparam logic [CODE_W:0]        MAX_EXT = (CODE_W+1)'(CODE_MAX);
    localparam logic [CODE_W:0]        QTR_EXT = (CODE_W+1)'(CODE_MAX / 4);
    localparam logic [CODE_W:0]        ACQ_EXT = (CODE_W+1)'(ACQ_STEP);
    localparam logic [CODE_W:0]        TRK_EXT = (CODE_W+1)'(TRK_STEP);
    localparam logic signed [NET_W-1:0] THR_P  = NET_W'(THR);
    localparam logic signed [NET_W-1:0] THR_N  = NET_W'(-THR);

    state_t                    state_q, state_d;
    logic [CODE_W-1:0]         code_q, code_d;
    logic [CODE_W-1:0]         pend_code_q, pend_code_d;
    logic                      pend_q, pend_d;
    logic [WC_W-1:0]           win_q, win_d;
    logic signed [NET_W-1:0]   net_q, net_d;
    logic [SC_W-1:0]           settle_q, settle_d;
    logic [QC_W-1:0]           quiet_q, quiet_d;
    logic [RC_W-1:0]           run_q, run_d;
    dir_t                      last_q, last_d;
    logic                      upd_q, upd_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;

    logic [CODE_W:0]           code_ext;
    logic [CODE_W:0]           step_ext;
    logic [CODE_W:0]           up_sum;
    logic [CODE_W:0]           sum_90;
    logic [CODE_W-1:0]         code_up;
    logic [CODE_W-1:0]         code_dn;
    logic signed [NET_W-1:0]   vote_delta;
    logic signed [NET_W-1:0]   net_sum;
    logic [WC_W-1:0]           win_sum;
    logic                      win_close;
    logic                      vote_ok;
    dir_t                      step_dir;
    logic                      stepping;
    logic                      same_dir;
    logic [QC_W-1:0]           quiet_inc;
    logic [RC_W-1:0]           run_nxt;

    // Wrap arithmetic is done one bit wider so code+step never overflows before the compare.
    assign code_ext = {1'b0, code_q};
    assign step_ext = (state_q == S_TRACK) ? TRK_EXT : ACQ_EXT;
    assign up_sum   = code_ext + step_ext;
    assign code_up  = CODE_W'((up_sum >= MAX_EXT) ? up_sum - MAX_EXT : up_sum);
    assign code_dn  = CODE_W'((code_ext < step_ext) ? code_ext + MAX_EXT - step_ext
                                                    : code_ext - step_ext);
    assign sum_90   = code_ext + QTR_EXT;

    always_comb begin
        vote_delta = '0;
        if (vote_up && !vote_dn) begin
            vote_delta = NET_W'(1);
        end else if (vote_dn && !vote_up) begin
            vote_delta = '1;
        end
    end

    assign net_sum   = net_q + vote_delta;
    assign win_sum   = win_q + WC_W'(1);
    assign win_close = (win_sum == WC_W'(WIN_LEN));
    assign vote_ok   = vote_vld && (settle_q == '0) && (state_q != S_IDLE);
    assign step_dir  = (net_sum >= THR_P) ? DIR_UP : ((net_sum <= THR_N) ? DIR_DN : DIR_NONE);
    assign stepping  = (step_dir != DIR_NONE);
    assign same_dir  = stepping && (step_dir == last_q);
    assign quiet_inc = quiet_q + QC_W'(1);
    assign run_nxt   = same_dir ? run_q + RC_W'(1) : RC_W'(1);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        pend_code_d = pend_code_q;
        pend_d      = pend_q;
        win_d       = win_q;
        net_d       = net_q;
        quiet_d     = quiet_q;
        run_d       = run_q;
        last_d      = last_q;
        upd_d       = 1'b0;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        settle_d    = (settle_q != '0) ? settle_q - SC_W'(1) : settle_q;

        if (load_req) begin
            ack_d    = 1'b1;
            settle_d = settle_q;
            if ({1'b0, load_code} >= MAX_EXT) begin
                err_d = 1'b1;
            end else begin
                code_d   = load_code;
                upd_d    = 1'b1;
                settle_d = SC_W'(SETTLE_CYC);
                win_d    = '0;
                net_d    = '0;
                pend_d   = 1'b0;
                quiet_d  = '0;
                run_d    = '0;
                last_d   = DIR_NONE;
                state_d  = en ? S_ACQ : S_IDLE;
            end
        end else if (!en) begin
            state_d = S_IDLE;
            win_d   = '0;
            net_d   = '0;
            pend_d  = 1'b0;
            quiet_d = '0;
            run_d   = '0;
            last_d  = DIR_NONE;
        end else begin
            if (state_q == S_IDLE) begin
                state_d = S_ACQ;
            end
            if (!freeze) begin
                // A decided step lands one cycle after the closing vote.
                if (pend_q) begin
                    code_d   = pend_code_q;
                    upd_d    = 1'b1;
                    settle_d = SC_W'(SETTLE_CYC);
                    pend_d   = 1'b0;
                end
                if (vote_ok) begin
                    if (!win_close) begin
                        win_d = win_sum;
                        net_d = net_sum;
                    end else begin
                        win_d = '0;
                        net_d = '0;
                        if (stepping) begin
                            pend_d      = 1'b1;
                            pend_code_d = (step_dir == DIR_UP) ? code_up : code_dn;
                            last_d      = step_dir;
                        end
                        if (state_q == S_ACQ) begin
                            quiet_d = same_dir ? '0 : quiet_inc;
                            if (!same_dir && (quiet_inc >= QC_W'(LOCK_WIN))) begin
                                state_d = S_TRACK;
                                quiet_d = '0;
                                run_d   = '0;
                            end
                        end else begin
                            run_d = stepping ? run_nxt : '0;
                            if (stepping && (run_nxt >= RC_W'(UNLOCK_RUN))) begin
                                state_d = S_ACQ;
                                run_d   = '0;
                                quiet_d = '0;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            pend_code_q <= '0;
            pend_q      <= 1'b0;
            win_q       <= '0;
            net_q       <= '0;
            settle_q    <= '0;
            quiet_q     <= '0;
            run_q       <= '0;
            last_q      <= DIR_NONE;
            upd_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            pend_code_q <= pend_code_d;
            pend_q      <= pend_d;
            win_q       <= win_d;
            net_q       <= net_d;
            settle_q    <= settle_d;
            quiet_q     <= quiet_d;
            run_q       <= run_d;
            last_q      <= last_d;
            upd_q       <= upd_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign code     = code_q;
    assign code_90  = CODE_W'((sum_90 >= MAX_EXT) ? sum_90 - MAX_EXT : sum_90);
    assign code_upd = upd_q;
    assign load_ack = ack_q;
    assign load_err = err_q;
    assign locked   = (state_q == S_TRACK);
    assign state    = state_q;

endmodule

// File: tb/tb_pmix_code_ctrl.sv
// Scoreboard bench for pmix_code_ctrl: a reference model queues expected code/load events,
// a negedge monitor pops and compares them whenever the DUT raises code_upd or load_ack.
module tb_pmix_code_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, freeze, vote_vld, vote_up, vote_dn, load_req;
    logic [8:0] load_code;
    logic       load_ack, load_err, code_upd, locked;
    logic [8:0] code, code_90;
    logic [1:0] state;

    pmix_code_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .freeze    (freeze),
        .vote_vld  (vote_vld),
        .vote_up   (vote_up),
        .vote_dn   (vote_dn),
        .load_req  (load_req),
        .load_code (load_code),
        .load_ack  (load_ack),
        .load_err  (load_err),
        .code      (code),
        .code_90   (code_90),
        .code_upd  (code_upd),
        .locked    (locked),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit upd;
        bit ack;
        bit err;
        int code;
        int st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc_cnt  = 0;
    int   upd_seen = 0;

    // Reference model: loop state in plain integers (state 0/1/2, direction +1/-1/0).
    int m_code = 0, m_state = 0, m_win = 0, m_net = 0, m_settle = 0;
    int m_quiet = 0, m_run = 0, m_last = 0, m_pend_code = 0;
    bit m_pend = 0;

    task automatic check(string name, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc_cnt);
        end
    endtask

    task automatic model_clear_loop();
        m_win = 0; m_net = 0; m_pend = 0; m_quiet = 0; m_run = 0; m_last = 0;
    endtask

    task automatic model_close_window();
        int d;
        d = (m_net >= 4) ? 1 : ((m_net <= -4) ? -1 : 0);
        m_win = 0;
        m_net = 0;
        if (d != 0) begin
            m_pend = 1;
            m_pend_code = ((m_code + d * ((m_state == 1) ? 8 : 1)) % 360 + 360) % 360;
        end
        if (m_state == 1) begin
            if (d != 0 && d == m_last) m_quiet = 0;
            else m_quiet++;
            if (m_quiet >= 8) begin m_state = 2; m_quiet = 0; m_run = 0; end
        end else begin
            if (d == 0) m_run = 0;
            else if (d == m_last) m_run++;
            else m_run = 1;
            if (m_run >= 4) begin m_state = 1; m_run = 0; m_quiet = 0; end
        end
        if (d != 0) m_last = d;
    endtask

    task automatic model_step();
        exp_t e;
        bit   ev;
        int   old_settle, old_state;
        ev = 0;
        e.cyc = 0; e.upd = 0; e.ack = 0; e.err = 0; e.code = 0; e.st = 0;
        old_settle = m_settle;
        old_state  = m_state;
        if (rst) begin
            m_code = 0; m_state = 0; m_settle = 0; m_pend_code = 0;
            model_clear_loop();
        end else if (load_req) begin
            ev = 1; e.ack = 1;
            if (int'(load_code) >= 360) begin
                e.err = 1;
            end else begin
                m_code = int'(load_code); e.upd = 1; m_settle = 4;
                model_clear_loop();
                m_state = en ? 1 : 0;
            end
        end else begin
            if (m_settle > 0) m_settle--;
            if (!en) begin
                m_state = 0;
                model_clear_loop();
            end else begin
                if (m_state == 0) m_state = 1;
                if (!freeze) begin
                    if (m_pend) begin
                        m_code = m_pend_code; m_pend = 0; m_settle = 4; ev = 1; e.upd = 1;
                    end
                    if (vote_vld && old_settle == 0 && old_state != 0) begin
                        m_win++;
                        if (vote_up && !vote_dn) m_net++;
                        else if (vote_dn && !vote_up) m_net--;
                        if (m_win == 16) model_close_window();
                    end
                end
            end
        end
        if (ev) begin
            e.cyc = cyc_cnt; e.code = m_code; e.st = m_state;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc_cnt++;
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        vote_vld = 0; vote_up = 0; vote_dn = 0; load_req = 0;
        repeat (n) tick();
    endtask

    task automatic vote(bit u, bit d);
        vote_vld = 1; vote_up = u; vote_dn = d;
        tick();
        vote_vld = 0; vote_up = 0; vote_dn = 0;
    endtask

    task automatic votes(int n, bit u, bit d);
        for (int i = 0; i < n; i++) vote(u, d);
    endtask

    task automatic window(int nu, int nd, int nb);
        votes(nu, 1, 0);
        votes(nd, 0, 1);
        votes(nb, 0, 0);
        idle(8);
    endtask

    task automatic do_load(int c);
        load_req = 1; load_code = 9'(c);
        tick();
        load_req = 0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            mon_e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missed_event: event due at cycle %0d (code %0d) absent at cycle %0d",
                     mon_e.cyc, mon_e.code, cyc_cnt);
        end
        if (code_upd === 1'b1 || load_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_event: code_upd=%0b load_ack=%0b code=%0d, expected none (cycle %0d)",
                         code_upd, load_ack, code, cyc_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_cycle",    cyc_cnt,        mon_e.cyc);
                check("evt_code_upd", int'(code_upd), int'(mon_e.upd));
                check("evt_load_ack", int'(load_ack), int'(mon_e.ack));
                check("evt_load_err", int'(load_err), int'(mon_e.err));
                check("evt_code",     int'(code),     mon_e.code);
                check("evt_code_90",  int'(code_90),  (mon_e.code + 90) % 360);
                check("evt_state",    int'(state),    mon_e.st);
                check("evt_locked",   int'(locked),   (mon_e.st == 2) ? 1 : 0);
            end
        end
        if (code_upd === 1'b1) upd_seen++;
    end

    initial begin
        int u0;
        int mode, pu, pd;
        bit seg_en;
        rst = 1; en = 0; freeze = 0; vote_vld = 0; vote_up = 0; vote_dn = 0;
        load_req = 0; load_code = '0;
        repeat (3) tick();
        rst = 0;
        check("rst_code",     int'(code),     0);
        check("rst_code_90",  int'(code_90),  90);
        check("rst_state",    int'(state),    0);
        check("rst_locked",   int'(locked),   0);
        check("rst_code_upd", int'(code_upd), 0);
        check("rst_load_ack", int'(load_ack), 0);
        check("rst_load_err", int'(load_err), 0);

        // Coarse up-step wraps 355 -> 3, visible one cycle after the closing vote
        en = 1;
        tick();
        check("t1_state_acq", int'(state), 1);
        do_load(355);
        idle(6);
        votes(16, 1, 0);
        check("t1_code_before", int'(code), 355);
        check("t1_upd_before",  int'(code_upd), 0);
        idle(1);
        check("t1_code",    int'(code),     3);
        check("t1_code_90", int'(code_90),  93);
        check("t1_upd",     int'(code_upd), 1);
        idle(1);
        check("t1_upd_pulse", int'(code_upd), 0);
        idle(6);

        // Down-step wraps 2 -> 354; net +2 window makes no change
        do_load(2);
        idle(6);
        window(0, 16, 0);
        check("t2_code",    int'(code),    354);
        check("t2_code_90", int'(code_90), 84);
        u0 = upd_seen;
        window(9, 7, 0);
        check("t2_code_hold", int'(code), 354);
        check("t2_no_upd",    upd_seen - u0, 0);

        // Lock after 8 alternating windows, unlock after 4 same-direction fine steps
        do_load(100);
        idle(6);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) window(16, 0, 0);
            else window(0, 16, 0);
        end
        check("t3_state_track", int'(state),  2);
        check("t3_locked",      int'(locked), 1);
        check("t3_code_lock",   int'(code),   100);
        window(16, 0, 0);
        check("t3_fine_step", int'(code), 101);
        window(16, 0, 0);
        window(16, 0, 0);
        check("t3_run3_state", int'(state), 2);
        window(16, 0, 0);
        check("t3_unlock_state",  int'(state),  1);
        check("t3_unlock_locked", int'(locked), 0);
        check("t3_unlock_code",   int'(code),   104);
        window(16, 0, 0);
        check("t3_coarse_again", int'(code), 112);

        // Rejected load, then wrap 359 -> 0 with a fine step in TRACK
        do_load(400);
        check("t4_ack",        int'(load_ack), 1);
        check("t4_err",        int'(load_err), 1);
        check("t4_code_kept",  int'(code),     112);
        check("t4_state_kept", int'(state),    1);
        idle(2);
        do_load(359);
        idle(6);
        for (int i = 0; i < 8; i++) window(0, 0, 16);
        check("t4_state_track", int'(state), 2);
        window(16, 0, 0);
        check("t4_wrap_code",    int'(code),    0);
        check("t4_wrap_code_90", int'(code_90), 90);

        // Settle blanking drops four votes; freeze holds the window
        votes(16, 1, 0);
        idle(1);
        check("t5_code1", int'(code), 1);
        u0 = upd_seen;
        votes(4, 1, 0);
        votes(15, 1, 0);
        check("t5_settle_code", int'(code), 1);
        check("t5_settle_upd",  upd_seen - u0, 0);
        vote(1, 0);
        idle(1);
        check("t5_code2", int'(code), 2);
        idle(8);
        u0 = upd_seen;
        votes(10, 1, 0);
        freeze = 1;
        votes(10, 1, 0);
        freeze = 0;
        votes(5, 1, 0);
        check("t5_freeze_code", int'(code), 2);
        check("t5_freeze_upd",  upd_seen - u0, 0);
        vote(1, 0);
        idle(1);
        check("t5_resume_code",  int'(code),  3);
        check("t5_resume_state", int'(state), 1);
        idle(7);

        // Reset mid-window; load colliding with a closing vote
        votes(10, 1, 0);
        rst = 1;
        tick();
        rst = 0;
        check("t6_rst_code",   int'(code),   0);
        check("t6_rst_state",  int'(state),  0);
        check("t6_rst_locked", int'(locked), 0);
        tick();
        do_load(50);
        idle(6);
        votes(15, 1, 0);
        vote_vld = 1; vote_up = 1; load_req = 1; load_code = 9'd60;
        tick();
        vote_vld = 0; vote_up = 0; load_req = 0;
        check("t6_load_win_code", int'(code),     60);
        check("t6_load_win_upd",  int'(code_upd), 1);
        check("t6_load_win_ack",  int'(load_ack), 1);
        idle(6);
        votes(15, 1, 0);
        idle(2);
        check("t6_window_cleared", int'(code), 60);
        vote(1, 0);
        idle(2);
        check("t6_after_close", int'(code), 68);

        // Randomized segments against the model
        for (int seg = 0; seg < 40; seg++) begin
            mode   = $urandom_range(0, 2);
            seg_en = ($urandom_range(0, 9) != 0);
            pu = (mode == 0) ? 80 : ((mode == 1) ? 15 : 45);
            pd = (mode == 0) ? 15 : ((mode == 1) ? 80 : 45);
            for (int k = 0; k < 64; k++) begin
                rst      = ($urandom_range(0, 1499) == 0);
                en       = seg_en;
                freeze   = ($urandom_range(0, 19) == 0);
                vote_vld = ($urandom_range(0, 9) < 8);
                vote_up  = ($urandom_range(0, 99) < pu);
                vote_dn  = ($urandom_range(0, 99) < pd);
                load_req = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 3) == 0) load_code = 9'($urandom_range(350, 511));
                else load_code = 9'($urandom_range(0, 359));
                tick();
            end
            rst = 0; freeze = 0;
            check("rnd_code",  int'(code),  m_code);
            check("rnd_state", int'(state), m_state);
        end
        en = 1;
        idle(10);
        check("end_code",   int'(code),   m_code);
        check("end_state",  int'(state),  m_state);
        check("end_locked", int'(locked), (m_state == 2) ? 1 : 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
